// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port RAM among NUM_REQ requesters.
// Optional read-wait timeout is built when RAM_ARB_TIMEOUT_EN is defined.
module ram_arbiter #(
   parameter int WIDTH          = 8,
   parameter int DEPTH          = 256,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic [NUM_REQ-1:0]                 i_req,
   input  logic [NUM_REQ-1:0]                 i_we,
   input  logic [NUM_REQ*$clog2(DEPTH)-1:0]   i_addr,
   input  logic [NUM_REQ*WIDTH-1:0]           i_wdata,
   output logic [NUM_REQ-1:0]                 o_gnt,
   output logic [WIDTH-1:0]                   o_rd_data,
   output logic [NUM_REQ-1:0]                 o_rd_dv,
   output logic                               o_rd_err,
   output logic                               o_busy,
   output logic                               o_ram_wr_dv,
   output logic [$clog2(DEPTH)-1:0]           o_ram_wr_addr,
   output logic [WIDTH-1:0]                   o_ram_wr_data,
   output logic                               o_ram_rd_en,
   output logic [$clog2(DEPTH)-1:0]           o_ram_rd_addr,
   input  logic [WIDTH-1:0]                   i_ram_rd_data,
   input  logic                               i_ram_rd_dv
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("ram_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      sel_q, sel_d;
   logic               we_q, we_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [WIDTH-1:0]   rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0] rd_dv_q, rd_dv_d;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rd_err_q, rd_err_d;
`endif

   logic [PW-1:0]      cand_idx  [NUM_REQ];
   logic [AW-1:0]      addr_arr  [NUM_REQ];
   logic [WIDTH-1:0]   wdata_arr [NUM_REQ];
   logic [NUM_REQ-1:0] req_rot;
   logic [NUM_REQ-1:0] sel_oh;
   logic               win_found;
   logic [PW-1:0]      win_idx;
   logic [PW-1:0]      ptr_inc;
   logic               ram_wr_dv;
   logic               ram_rd_en;

   // Slot gi of the rotated view holds requester (ptr + gi) mod NUM_REQ
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [PW:0] cand_sum;
      assign cand_sum      = {1'b0, ptr_q} + (PW+1)'(gi);
      assign cand_idx[gi]  = (cand_sum >= (PW+1)'(NUM_REQ)) ?
                             PW'(cand_sum - (PW+1)'(NUM_REQ)) : cand_sum[PW-1:0];
      assign req_rot[gi]   = i_req[cand_idx[gi]];
      assign addr_arr[gi]  = i_addr[gi*AW +: AW];
      assign wdata_arr[gi] = i_wdata[gi*WIDTH +: WIDTH];
      assign sel_oh[gi]    = (sel_q == PW'(gi));
      assign o_gnt[gi]     = (state_q == ISSUE) && sel_oh[gi];
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[i];
         end
      end
   end

   assign ptr_inc = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      rd_dv_d   = '0;
      ram_wr_dv = 1'b0;
      ram_rd_en = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      rd_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               sel_d   = win_idx;
               we_d    = i_we[win_idx];
               addr_d  = addr_arr[win_idx];
               wdata_d = wdata_arr[win_idx];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ptr_d = ptr_inc;
            if (we_q) begin
               ram_wr_dv = 1'b1;
               state_d   = IDLE;
            end else begin
               ram_rd_en = 1'b1;
               // A RAM that answers in the issue cycle is accepted right away
               if (i_ram_rd_dv) begin
                  rd_dv_d   = sel_oh;
                  rd_data_d = i_ram_rd_data;
                  state_d   = IDLE;
               end else begin
                  state_d = RD_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         RD_WAIT: begin
            if (i_ram_rd_dv) begin
               rd_dv_d   = sel_oh;
               rd_data_d = i_ram_rd_data;
               state_d   = IDLE;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rd_dv_d   = sel_oh;
               rd_err_d  = 1'b1;
               rd_data_d = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         rd_dv_q   <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         rd_err_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         rd_dv_q   <= rd_dv_d;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         rd_err_q  <= rd_err_d;
`endif
      end
   end

   assign o_rd_data     = rd_data_q;
   assign o_rd_dv       = rd_dv_q;
   assign o_busy        = (state_q != IDLE);
   assign o_ram_wr_dv   = ram_wr_dv;
   assign o_ram_wr_addr = addr_q;
   assign o_ram_wr_data = wdata_q;
   assign o_ram_rd_en   = ram_rd_en;
   assign o_ram_rd_addr = addr_q;
`ifdef RAM_ARB_TIMEOUT_EN
   assign o_rd_err      = rd_err_q;
`else
   assign o_rd_err      = 1'b0;
`endif

endmodule
